// File: rtl/axis_rx_frame_stats.sv
`timescale 1ns/1ps
// axis_rx_frame_stats
//
// RX-side AXI4-Stream register slice with per-frame length measurement and
// saturating frame statistics. Sits between the LMAC master stream and the
// DMA write engine in the dclk domain. Beats pass through unmodified with
// one cycle of latency; a skid entry keeps full throughput under
// backpressure.
//
// Optional feature: define AXIS_RX_FRAME_STATS_BYTECNT_EN to build the
// cnt_bytes port and its 32-bit total-byte accumulator.
//
// Ports:
//   dclk, rst                 clock and synchronous active-high reset
//   s_axis_*                  input stream (tvalid/tready/tdata/tkeep/tlast)
//   m_axis_*                  output stream (same fields)
//   stats_clr                 synchronous clear of all statistics counters
//   frame_done                one-cycle pulse after a frame's last beat
//   frame_len                 byte length of the latest frame (saturating)
//   frame_runt, frame_giant   classification of the latest frame
//   cnt_good/runt/giant       saturating frame counters (CNT_W bits)
//   cnt_bytes                 total bytes counted (optional, 32 bits)

module axis_rx_frame_stats #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic             dclk,
    input  logic             rst,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    input  logic             stats_clr,
    output logic             frame_done,
    output logic [15:0]      frame_len,
    output logic             frame_runt,
    output logic             frame_giant,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_runt,
    output logic [CNT_W-1:0] cnt_giant
`ifdef AXIS_RX_FRAME_STATS_BYTECNT_EN
    ,
    output logic [31:0]      cnt_bytes
`endif
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_IN_FRAME = 1'b1;

    localparam logic [16:0] MIN_L = 17'(MIN_LEN);
    localparam logic [16:0] MAX_L = 17'(MAX_LEN);

    // Number of valid bytes in a beat; keep is counted bit by bit so a
    // non-contiguous mask still yields a sensible byte count.
    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Data path: main register feeds the output, skid catches the one
    // beat that can arrive in the cycle the output stalls.
    // ------------------------------------------------------------------
    logic        main_valid;
    logic [63:0] main_data;
    logic [7:0]  main_keep;
    logic        main_last;
    logic        skid_full;
    logic [63:0] skid_data;
    logic [7:0]  skid_keep;
    logic        skid_last;

    logic accept;
    logic main_free;

    // tready comes straight from the skid flop, so it is a registered signal
    assign s_axis_tready = !skid_full;
    assign accept        = s_axis_tvalid && !skid_full;
    assign main_free     = !main_valid || m_axis_tready;

    assign m_axis_tvalid = main_valid;
    assign m_axis_tdata  = main_data;
    assign m_axis_tkeep  = main_keep;
    assign m_axis_tlast  = main_last;

    always_ff @(posedge dclk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_keep  <= '0;
            main_last  <= 1'b0;
            skid_full  <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            skid_last  <= 1'b0;
        end else if (main_free) begin
            // skid is always older than any new input, so it drains first;
            // no input can be accepted while skid is occupied
            if (skid_full) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_keep  <= skid_keep;
                main_last  <= skid_last;
                skid_full  <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= s_axis_tdata;
                main_keep  <= s_axis_tkeep;
                main_last  <= s_axis_tlast;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
            skid_data <= s_axis_tdata;
            skid_keep <= s_axis_tkeep;
            skid_last <= s_axis_tlast;
        end
    end

    // ------------------------------------------------------------------
    // Frame measurement, taken from the input side so it does not depend
    // on output backpressure.
    // ------------------------------------------------------------------
    logic [0:0]  state;
    logic [16:0] acc;
    logic [16:0] acc_base;
    logic [17:0] acc_sum;
    logic [16:0] acc_next;
    logic [15:0] len_sat;
    logic        is_runt;
    logic        is_giant;
    logic        eof;

    // A frame's first beat always starts counting from zero
    assign acc_base = (state == ST_IDLE) ? 17'd0 : acc;
    assign acc_sum  = {1'b0, acc_base} + {14'd0, popcount8(s_axis_tkeep)};
    assign acc_next = acc_sum[17] ? 17'h1FFFF : acc_sum[16:0];
    assign len_sat  = acc_next[16] ? 16'hFFFF : acc_next[15:0];
    assign is_runt  = (acc_next < MIN_L);
    assign is_giant = (acc_next > MAX_L);
    assign eof      = accept && s_axis_tlast;

    always_ff @(posedge dclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc         <= '0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            frame_runt  <= 1'b0;
            frame_giant <= 1'b0;
        end else begin
            frame_done <= eof;
            if (accept) begin
                if (s_axis_tlast) begin
                    state       <= ST_IDLE;
                    acc         <= '0;
                    frame_len   <= len_sat;
                    frame_runt  <= is_runt;
                    frame_giant <= is_giant;
                end else begin
                    state <= ST_IN_FRAME;
                    acc   <= acc_next;
                end
            end
        end
    end

    // Statistics counters: a clear beats a coincident end of frame, and
    // every counter sticks at all-ones instead of wrapping.
    always_ff @(posedge dclk) begin
        if (rst || stats_clr) begin
            cnt_good  <= '0;
            cnt_runt  <= '0;
            cnt_giant <= '0;
        end else if (eof) begin
            if (is_runt) begin
                if (cnt_runt != '1) cnt_runt <= cnt_runt + CNT_W'(1);
            end else if (is_giant) begin
                if (cnt_giant != '1) cnt_giant <= cnt_giant + CNT_W'(1);
            end else begin
                if (cnt_good != '1) cnt_good <= cnt_good + CNT_W'(1);
            end
        end
    end

`ifdef AXIS_RX_FRAME_STATS_BYTECNT_EN
    logic [32:0] bytes_sum;

    assign bytes_sum = {1'b0, cnt_bytes} + {17'd0, len_sat};

    // Total bytes of every frame, good or bad, saturating at all-ones
    always_ff @(posedge dclk) begin
        if (rst || stats_clr) begin
            cnt_bytes <= '0;
        end else if (eof) begin
            cnt_bytes <= bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
        end
    end
`endif

endmodule
